// File: rtl/instr_encoder_if.sv
// Command and instruction bus of the instruction encoder.
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its payload
// steady until that edge, and ready never depends on the transfer it enables.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [2:0]            cmd_kind_i;
  logic [4:0]            rs_i;
  logic [4:0]            rt_i;
  logic [4:0]            rd_i;
  logic [4:0]            shamt_i;
  logic [5:0]            funct_i;
  logic [15:0]           imm_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;

  // Command source and instruction consumer side (program loader / bench).
  modport master (
    output cmd_valid_i, cmd_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i,
    output instr_ready_i,
    input  cmd_ready_o, instr_valid_o, instr_o, instr_addr_o
  );

  // Encoder side.
  modport slave (
    input  cmd_valid_i, cmd_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i,
    input  instr_ready_i,
    output cmd_ready_o, instr_valid_o, instr_o, instr_addr_o
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder with a 2-entry issue buffer. Packs instruction-class
// commands into 32-bit words, tags each with a word-aligned address and
// presents them through a valid/ready output.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  instr_encoder_if.slave       bus,
  output logic [15:0]          count_o,
  output logic                 err_o,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] BASE_FULL  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = {BASE_FULL[ADDR_WIDTH-1:2], 2'b00};

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [31:0]           head_instr_q;
  logic [ADDR_WIDTH-1:0] head_addr_q;
  logic [31:0]           tail_instr_q;
  logic [ADDR_WIDTH-1:0] tail_addr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           count_q;
  logic                  err_q;

  logic                  flush;
  logic                  accept;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic [31:0]           new_instr;

  // Pack one command into a MIPS word; kinds 6/7 never reach the buffer.
  function automatic logic [31:0] pack_word(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm
  );
    logic [5:0] op;
    case (kind)
      3'd1:    op = 6'b100011;
      3'd2:    op = 6'b101011;
      3'd3:    op = 6'b000100;
      3'd4:    op = 6'b001000;
      3'd5:    op = 6'b001010;
      default: op = 6'b000000;
    endcase
    if (kind == 3'd0) pack_word = {op, rs, rt, rd, shamt, funct};
    else              pack_word = {op, rs, rt, imm};
  endfunction

  // Handshakes and output gating; reset and clear block both sides at once.
  always_comb begin
    flush             = rst_i || clear_i;
    bus.cmd_ready_o   = !flush && (state_q != FULL);
    bus.instr_valid_o = !flush && (state_q != EMPTY);
    bus.instr_o       = bus.instr_valid_o ? head_instr_q : 32'd0;
    bus.instr_addr_o  = bus.instr_valid_o ? head_addr_q : '0;
    count_o           = flush ? 16'd0 : count_q;
    err_o             = flush ? 1'b0 : err_q;
    dbg_state         = state_q;
    accept            = bus.cmd_valid_i && bus.cmd_ready_o;
    legal             = !(bus.cmd_kind_i[2] && bus.cmd_kind_i[1]);
    push              = accept && legal;
    pop               = bus.instr_valid_o && bus.instr_ready_i;
    new_instr         = pack_word(bus.cmd_kind_i, bus.rs_i, bus.rt_i, bus.rd_i,
                                  bus.shamt_i, bus.funct_i, bus.imm_i);
  end

  // Buffer occupancy: push+pop in ONE keeps ONE; FULL never sees a push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Buffer state and entry storage; the head always sits in the head registers.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q      <= EMPTY;
      head_instr_q <= 32'd0;
      head_addr_q  <= '0;
      tail_instr_q <= 32'd0;
      tail_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        EMPTY: if (push) begin
          head_instr_q <= new_instr;
          head_addr_q  <= addr_q;
        end
        ONE: if (push && pop) begin
          head_instr_q <= new_instr;
          head_addr_q  <= addr_q;
        end else if (push) begin
          tail_instr_q <= new_instr;
          tail_addr_q  <= addr_q;
        end
        FULL: if (pop) begin
          head_instr_q <= tail_instr_q;
          head_addr_q  <= tail_addr_q;
        end
        default: ;
      endcase
    end
  end

  // Next-address counter, delivered-word counter and sticky illegal flag.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      addr_q  <= START_ADDR;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      if (push) addr_q <= addr_q + ADDR_WIDTH'(4);
      if (pop && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      if (accept && !legal) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_instr_encoder;

  logic clk;
  logic rst;
  logic clear;
  logic clear_w;
  logic [15:0] count;
  logic        err;
  logic [1:0]  dbg_state;
  logic [15:0] count_w;
  logic        err_w;
  logic [1:0]  dbg_state_w;

  int checks;
  int failures;
  bit model_on;

  instr_encoder_if #(.ADDR_WIDTH(10)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(4))  bus_w ();

  instr_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bus),
    .count_o(count), .err_o(err), .dbg_state(dbg_state)
  );

  // Narrow-address instance; base 13 must be treated as 12.
  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(13)) dut_w (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_w), .bus(bus_w),
    .count_o(count_w), .err_o(err_w), .dbg_state(dbg_state_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds {instr, addr} of words waiting on the output side.
  logic [41:0] exp_q[$];
  logic [9:0]  m_addr;
  logic [15:0] m_count;
  logic        m_err;

  function automatic logic [31:0] enc(input logic [2:0] kind, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn,
                                      input logic [15:0] imm);
    logic [5:0] op_tab [6];
    logic [31:0] w;
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A};
    w = 32'(op_tab[kind]) << 26;
    w = w | (32'(rs) << 21) | (32'(rt) << 16);
    if (kind == 3'd0) w = w | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else              w = w | 32'(imm);
    return w;
  endfunction

  always @(posedge clk) begin
    bit can_take;
    bit has_head;
    if (rst || clear) begin
      exp_q.delete();
      m_addr  = 10'd0;
      m_count = 16'd0;
      m_err   = 1'b0;
    end else begin
      can_take = exp_q.size() < 2;
      has_head = exp_q.size() > 0;
      if (has_head && bus.instr_ready_i) begin
        void'(exp_q.pop_front());
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
      if (bus.cmd_valid_i && can_take) begin
        if (bus.cmd_kind_i >= 3'd6) m_err = 1'b1;
        else begin
          exp_q.push_back({enc(bus.cmd_kind_i, bus.rs_i, bus.rt_i, bus.rd_i,
                               bus.shamt_i, bus.funct_i, bus.imm_i), m_addr});
          m_addr = m_addr + 10'd4;
        end
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    bit live;
    logic [41:0] head;
    if (model_on) begin
      live = !rst && !clear;
      head = (live && exp_q.size() > 0) ? exp_q[0] : 42'd0;
      chk("m_cmd_ready", bus.cmd_ready_o, live && exp_q.size() < 2);
      chk("m_instr_valid", bus.instr_valid_o, live && exp_q.size() > 0);
      chk("m_instr", bus.instr_o, head[41:10]);
      chk("m_instr_addr", bus.instr_addr_o, head[9:0]);
      chk("m_count", count, live ? m_count : 16'd0);
      chk("m_err", err, live ? m_err : 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_kind_i  = k;
    bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.shamt_i = sh;
    bus.funct_i = fn; bus.imm_i = imm;
  endtask

  task automatic idle();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.instr_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic head_is(input string name, input logic [31:0] w, input logic [9:0] a);
    chk({name, "_valid"}, bus.instr_valid_o, 1'b1);
    chk({name, "_instr"}, bus.instr_o, w);
    chk({name, "_addr"}, bus.instr_addr_o, a);
  endtask

  // Fill FULL with err set, then flush with clear or reset.
  task automatic flush_test(input bit use_rst);
    string tag;
    tag = use_rst ? "rst" : "clr";
    do_reset();
    bus.instr_ready_i = 1'b1;
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd9);
    tick();
    idle();
    tick();
    bus.instr_ready_i = 1'b0;
    set_cmd(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1);
    tick();
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd5);
    tick();
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd6);
    tick();
    idle();
    chk({tag, "_pre_err"}, err, 1'b1);
    chk({tag, "_pre_full"}, bus.cmd_ready_o, 1'b0);
    chk({tag, "_pre_count"}, count, 16'd1);
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    #1;
    chk({tag, "_during_ready"}, bus.cmd_ready_o, 1'b0);
    chk({tag, "_during_valid"}, bus.instr_valid_o, 1'b0);
    tick();
    rst = 1'b0;
    clear = 1'b0;
    #1;
    chk({tag, "_after_valid"}, bus.instr_valid_o, 1'b0);
    chk({tag, "_after_err"}, err, 1'b0);
    chk({tag, "_after_count"}, count, 16'd0);
    chk({tag, "_after_ready"}, bus.cmd_ready_o, 1'b1);
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd1);
    tick();
    idle();
    head_is({tag, "_next"}, 32'h20850001, 10'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    model_on = 1'b0;
    rst = 1'b1;
    clear = 1'b0;
    clear_w = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_kind_i = '0; bus.rs_i = '0; bus.rt_i = '0;
    bus.rd_i = '0; bus.shamt_i = '0; bus.funct_i = '0; bus.imm_i = '0;
    bus.instr_ready_i = 1'b0;
    bus_w.cmd_valid_i = 1'b0; bus_w.cmd_kind_i = 3'd4; bus_w.rs_i = 5'd4; bus_w.rt_i = 5'd5;
    bus_w.rd_i = '0; bus_w.shamt_i = '0; bus_w.funct_i = '0; bus_w.imm_i = 16'd1;
    bus_w.instr_ready_i = 1'b0;
    tick();
    model_on = 1'b1;
    do_reset();

    // Reset state.
    chk("rst_ready", bus.cmd_ready_o, 1'b1);
    chk("rst_valid", bus.instr_valid_o, 1'b0);
    chk("rst_count", count, 16'd0);
    chk("rst_err", err, 1'b0);

    // R-type add.
    set_cmd(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF);
    tick();
    idle();
    head_is("rtype", 32'h00221820, 10'd0);
    bus.instr_ready_i = 1'b1;
    tick();
    chk("rtype_count", count, 16'd1);
    chk("rtype_drained", bus.instr_valid_o, 1'b0);

    // I-types streamed with the consumer always ready.
    do_reset();
    bus.instr_ready_i = 1'b1;
    set_cmd(3'd1, 5'd4, 5'd5, 5'd31, 5'd31, 6'h3F, 16'd8);
    tick();
    head_is("lw", 32'h8C850008, 10'd0);
    set_cmd(3'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd8);
    tick();
    head_is("sw", 32'hAC850008, 10'd4);
    set_cmd(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF);
    tick();
    head_is("beq", 32'h1085FFFF, 10'd8);
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd1);
    tick();
    head_is("addi", 32'h20850001, 10'd12);
    set_cmd(3'd5, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd7);
    tick();
    head_is("slti", 32'h28850007, 10'd16);
    idle();
    tick();
    chk("itype_count", count, 16'd5);

    // Back-pressure.
    do_reset();
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd1);
    tick();
    chk("bp_one_ready", bus.cmd_ready_o, 1'b1);
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd2);
    tick();
    chk("bp_full_ready", bus.cmd_ready_o, 1'b0);
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd3);
    tick();
    chk("bp_hold_ready", bus.cmd_ready_o, 1'b0);
    head_is("bp_hold", 32'h20850001, 10'd0);
    bus.instr_ready_i = 1'b1;
    tick();
    head_is("bp_second", 32'h20850002, 10'd4);
    chk("bp_reopen_ready", bus.cmd_ready_o, 1'b1);
    tick();
    idle();
    head_is("bp_third", 32'h20850003, 10'd8);
    tick();
    chk("bp_empty", bus.instr_valid_o, 1'b0);

    // Illegal kind between two addi commands.
    do_reset();
    bus.instr_ready_i = 1'b1;
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd1);
    tick();
    head_is("ill_first", 32'h20850001, 10'd0);
    chk("ill_err_before", err, 1'b0);
    set_cmd(3'd7, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd9);
    tick();
    chk("ill_err_set", err, 1'b1);
    chk("ill_dropped", bus.instr_valid_o, 1'b0);
    set_cmd(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd2);
    tick();
    head_is("ill_second", 32'h20850002, 10'd4);
    idle();
    tick();
    chk("ill_count", count, 16'd2);
    chk("ill_err_sticky", err, 1'b1);

    // Flush via clear, then via reset.
    flush_test(1'b0);
    flush_test(1'b1);

    // Address wrap on the 4-bit instance.
    do_reset();
    bus_w.instr_ready_i = 1'b1;
    bus_w.cmd_valid_i = 1'b1;
    tick();
    chk("wrap_first_addr", bus_w.instr_addr_o, 4'd12);
    chk("wrap_first_valid", bus_w.instr_valid_o, 1'b1);
    tick();
    bus_w.cmd_valid_i = 1'b0;
    chk("wrap_second_addr", bus_w.instr_addr_o, 4'd0);
    chk("wrap_second_instr", bus_w.instr_o, 32'h20850001);
    tick();

    // Randomized traffic including illegal kinds, clears and resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.cmd_valid_i   = ($urandom_range(0, 3) != 0);
      bus.cmd_kind_i    = 3'($urandom_range(0, 7));
      bus.rs_i          = 5'($urandom);
      bus.rt_i          = 5'($urandom);
      bus.rd_i          = 5'($urandom);
      bus.shamt_i       = 5'($urandom);
      bus.funct_i       = 6'($urandom);
      bus.imm_i         = 16'($urandom);
      bus.instr_ready_i = ($urandom_range(0, 2) != 0);
      clear             = ($urandom_range(0, 150) == 0);
      rst               = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;
    clear = 1'b0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and issue buffer for the single-cycle MIPS core. It is the inverse of the opcode decoder: it accepts instruction-class commands with register and immediate fields and packs them into 32-bit MIPS words. It tags each word with a sequential word-aligned instruction-memory address and presents the results through a 2-entry valid/ready buffer. It sits between the test/program-load path and the instruction memory write port.

## Interface
- ADDR_WIDTH, 10: byte-address width of instr_addr_o.
- BASE_ADDR, 0: first address issued after reset or clear. Bits [1:0] are ignored and treated as 0.

- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous restart. Flushes the buffer and resets the address, count and error state.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o at the clock edge.
- cmd_kind_i  in  3  instruction class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 slti; 6 and 7 are illegal.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields.
- funct_i  in  6  R-type function field.
- imm_i  in  16  immediate / offset.
- instr_valid_o  out  1  buffer head valid.
- instr_ready_i  in  1  consumer takes the head when instr_valid_o && instr_ready_i.
- instr_o  out  32  packed instruction at the head.
- instr_addr_o  out  ADDR_WIDTH  byte address of the head word.
- count_o  out  16  words delivered on the output side.
- err_o  out  1  sticky illegal-command flag.

## Operation
- Opcode map:
  - R-type 6'b000000
  - lw 6'b100011
  - sw 6'b101011
  - beq 6'b000100
  - addi 6'b001000
  - slti 6'b001010
- Packing:
  - R-type: {op, rs, rt, rd, shamt, funct}.
  - All others: {op, rs, rt, imm}. rd_i, shamt_i and funct_i are ignored.
- Buffer: a 2-entry FIFO of {instr, addr}, with states EMPTY, ONE and FULL.
  - Push only: EMPTY→ONE, ONE→FULL.
  - Pop only: FULL→ONE, ONE→EMPTY.
  - Push and pop together in ONE: stays ONE, and the new entry becomes the head.
- cmd_ready_o = !rst_i && !clear_i && (state != FULL).
  - There is no bypass: when FULL, a same-cycle pop does not make cmd_ready_o high.
- Address counter:
  - Holds the address assigned to the next legal command.
  - Starts at {BASE_ADDR[ADDR_WIDTH-1:2], 2'b00}.
  - Adds 4 on each legal accept and wraps modulo 2^ADDR_WIDTH.
- Illegal kind (6 or 7):
  - The handshake completes and the command is consumed but dropped. Nothing is pushed and the address is not advanced.
  - err_o is set and stays set until rst_i or clear_i.
- count_o increments on each output handshake and saturates at 16'hFFFF.
- instr_o and instr_addr_o are 0 whenever instr_valid_o is 0.
- Reset (rst_i high):
  - State goes to EMPTY and the address counter to BASE_ADDR.
  - count_o, err_o, instr_valid_o, instr_o and instr_addr_o read 0.
  - cmd_ready_o reads 0 during reset and 1 on the first cycle after it.
  - Reset aborts any in-flight handshake.
- clear_i: same effect as reset.
  - While clear_i is high, cmd_ready_o = 0 and instr_valid_o = 0, so no handshake completes on either side that cycle.
  - rst_i has priority over clear_i.

## Timing
- Accepting a command into EMPTY at edge N gives instr_valid_o = 1 with the packed word from edge N (registered, 1-cycle latency).
- Output is held stable while instr_valid_o && !instr_ready_i.
- Sustained throughput is 1 word/cycle with instr_ready_i held high.
- Back-pressure: two accepted commands with instr_ready_i low give FULL and cmd_ready_o = 0 on the next cycle. One pop then makes cmd_ready_o = 1 in the following cycle.
- err_o rises on the edge at which the illegal command is accepted.
- count_o updates on the edge of the output handshake.

## Test plan
- R-type add: rs=1, rt=2, rd=3, shamt=0, funct=6'h20 → instr_o=32'h00221820 at addr 0 one cycle after accept. count_o goes to 1 after the pop.
- I-types with rs=4, rt=5:
  - lw imm=8 → 32'h8C850008
  - sw imm=8 → 32'hAC850008
  - beq imm=16'hFFFF → 32'h1085FFFF
  - addi imm=1 → 32'h20850001
  - slti imm=7 → 32'h28850007
  - Addresses are 0, 4, 8, 12, 16.
- Back-pressure: instr_ready_i=0 with 3 commands offered → only 2 accepted and cmd_ready_o=0. Then instr_ready_i=1 → words drain in order and the third command is accepted only after the FULL→ONE transition.
- Illegal kind 7 between two addi commands → err_o=1 and stays set. Only 2 words emitted, at addr 0 and 4.
- Wrap: ADDR_WIDTH=4, BASE_ADDR=12, 2 commands → addresses 12 then 0.
- Flush: clear_i pulsed with FULL and err_o=1 → next cycle instr_valid_o=0, err_o=0, count_o=0, and the next word is at BASE_ADDR. Repeat using rst_i mid-stream and expect the identical result.
